// File: rtl/execute_stage.sv
// RV32I execute stage: operand muxing, ALU, branch comparator and branch decision,
// with the result, taken flag and redirect request registered onto the E/M boundary.
module execute_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC_RESULT = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      shamt,
    input  logic            pc_reg1_sel,
    input  logic            b_sel,
    input  logic            rs2_shamt_sel,
    input  logic [3:0]      alu_sel,
    input  logic            unsign,
    input  logic            brn_enable,
    input  logic [1:0]      brn_signal,
    input  logic            pc_jump,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_out,
    output logic            br_tk,
    output logic            redirect,
    output logic            br_eq,
    output logic            br_lt
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;
    localparam logic [3:0] OP_JALR = 4'd11;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] alu_next;
    logic            br_tk_next;

    assign op_a = pc_reg1_sel ? pc : rs1_data;
    assign op_b = b_sel ? imm : (rs2_shamt_sel ? XLEN'(shamt) : rs2_data);
    assign sh   = op_b[SHW-1:0];

    // ALU
    always_comb begin
        alu_next = '0;
        case (alu_sel)
            OP_ADD:  alu_next = op_a + op_b;
            OP_SUB:  alu_next = op_a - op_b;
            OP_SLL:  alu_next = op_a << sh;
            OP_SLT:  alu_next = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_next = XLEN'(op_a < op_b);
            OP_XOR:  alu_next = op_a ^ op_b;
            OP_SRL:  alu_next = op_a >> sh;
            OP_SRA:  alu_next = $signed(op_a) >>> sh;
            OP_OR:   alu_next = op_a | op_b;
            OP_AND:  alu_next = op_a & op_b;
            OP_PASS: alu_next = op_b;
            OP_JALR: alu_next = (op_a + op_b) & ~XLEN'(1);
            default: alu_next = '0;
        endcase
    end

    // Branch compare works on raw register operands, not the ALU muxes
    assign br_eq = (rs1_data == rs2_data);
    assign br_lt = unsign ? (rs1_data < rs2_data) : ($signed(rs1_data) < $signed(rs2_data));

    always_comb begin
        br_tk_next = 1'b0;
        if (brn_enable) begin
            case (brn_signal)
                2'b00:   br_tk_next = br_eq;
                2'b01:   br_tk_next = !br_eq;
                2'b10:   br_tk_next = br_lt;
                default: br_tk_next = !br_lt;
            endcase
        end
    end

    // E/M boundary registers; bubbles still update alu_out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            br_tk     <= 1'b0;
            redirect  <= 1'b0;
            alu_out   <= RESET_PC_RESULT;
        end else begin
            out_valid <= in_valid;
            br_tk     <= br_tk_next & in_valid;
            redirect  <= (br_tk_next | pc_jump) & in_valid;
            alu_out   <= alu_next;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  shamt;
    logic        pc_reg1_sel, b_sel, rs2_shamt_sel;
    logic [3:0]  alu_sel;
    logic        unsign, brn_enable, pc_jump;
    logic [1:0]  brn_signal;
    logic        out_valid, br_tk, redirect, br_eq, br_lt;
    logic [31:0] alu_out;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .shamt(shamt),
        .pc_reg1_sel(pc_reg1_sel), .b_sel(b_sel), .rs2_shamt_sel(rs2_shamt_sel),
        .alu_sel(alu_sel), .unsign(unsign), .brn_enable(brn_enable),
        .brn_signal(brn_signal), .pc_jump(pc_jump), .out_valid(out_valid),
        .alu_out(alu_out), .br_tk(br_tk), .redirect(redirect),
        .br_eq(br_eq), .br_lt(br_lt)
    );

    always #5 clock = ~clock;

    // Reference model: plain integer arithmetic on 64-bit values
    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          p  = longint'(64'd1 << b[4:0]);
        case (op)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua - ub);
            4'd2:  return 32'(ua * longint'(p));
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return 32'(ua / longint'(p));
            4'd7:  return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return 32'((ua + ub) / 2 * 2);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_lt(input logic [31:0] x, input logic [31:0] y, input logic u);
        if (u) return {32'd0, x} < {32'd0, y};
        return longint'($signed(x)) < longint'($signed(y));
    endfunction

    function automatic logic model_tk(input logic [31:0] x, input logic [31:0] y, input logic u,
                                      input logic en, input logic [1:0] sig);
        logic eq = (x == y);
        logic lt = model_lt(x, y, u);
        if (!en) return 1'b0;
        case (sig)
            2'b00: return eq;
            2'b01: return !eq;
            2'b10: return lt;
            default: return !lt;
        endcase
    endfunction

    function automatic logic [31:0] cur_a();
        return pc_reg1_sel ? pc : rs1_data;
    endfunction

    function automatic logic [31:0] cur_b();
        return b_sel ? imm : (rs2_shamt_sel ? {27'd0, shamt} : rs2_data);
    endfunction

    task automatic clear_inputs();
        in_valid = 1'b1; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; shamt = '0;
        pc_reg1_sel = 1'b0; b_sel = 1'b0; rs2_shamt_sel = 1'b0; alu_sel = 4'd0;
        unsign = 1'b0; brn_enable = 1'b0; brn_signal = 2'b00; pc_jump = 1'b0;
    endtask

    task automatic randomize_inputs();
        in_valid = 1'($urandom); pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        imm = $urandom; shamt = 5'($urandom); pc_reg1_sel = 1'($urandom);
        b_sel = 1'($urandom); rs2_shamt_sel = 1'($urandom); alu_sel = 4'($urandom);
        unsign = 1'($urandom); brn_enable = 1'($urandom); brn_signal = 2'($urandom);
        pc_jump = 1'($urandom);
        if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
    endtask

    task automatic test_reset();
        randomize_inputs();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (alu_out !== 32'd0 || br_tk !== 1'b0 || redirect !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got alu=%h tk=%b rd=%b v=%b want 0/0/0/0",
                     alu_out, br_tk, redirect, out_valid);
        end
        clear_inputs();
        rs1_data = 32'd3; rs2_data = 32'd4;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (alu_out !== 32'd7 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got alu=%h v=%b want 00000007/1", alu_out, out_valid);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  ops  [16];
        logic [31:0] want [16];
        ops  = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11,
                 4'd12, 4'd13, 4'd14, 4'd15};
        want = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FF00, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
                 32'd1, 32'd0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'd0, 32'd4, 32'hFFFF_FFF4,
                 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 16; i++) begin
            clear_inputs();
            rs1_data = 32'hFFFF_FFF0; rs2_data = 32'h0000_0004; alu_sel = ops[i];
            @(posedge clock); #1;
            total++;
            if (alu_out !== want[i]) begin
                bad++;
                $display("FAIL alu_sweep op=%0d: got %h want %h", ops[i], alu_out, want[i]);
            end
        end
    endtask

    task automatic test_operand_mux();
        clear_inputs();
        pc = 32'h0100_0000; pc_reg1_sel = 1'b1; b_sel = 1'b1; imm = 32'd8; rs1_data = 32'h55;
        @(posedge clock); #1;
        total++;
        if (alu_out !== 32'h0100_0008) begin
            bad++; $display("FAIL mux_pc_imm: got %h want 01000008", alu_out);
        end
        clear_inputs();
        rs2_shamt_sel = 1'b1; shamt = 5'd31; rs1_data = 32'h8000_0000; rs2_data = 32'd1;
        alu_sel = 4'd7;
        @(posedge clock); #1;
        total++;
        if (alu_out !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL mux_shamt_sra: got %h want ffffffff", alu_out);
        end
        clear_inputs();
        rs1_data = 32'h1001; b_sel = 1'b1; imm = 32'd0; rs2_data = 32'h7; alu_sel = 4'd11;
        @(posedge clock); #1;
        total++;
        if (alu_out !== 32'h1000) begin
            bad++; $display("FAIL mux_jalr: got %h want 00001000", alu_out);
        end
    endtask

    task automatic test_branch();
        // rs1, rs2, unsign, enable, signal, expected lt, expected taken
        logic [31:0] r1 [12];
        logic [31:0] r2 [12];
        logic [4:0]  ctl [12];
        logic [1:0]  exp [12];
        r1  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        r2  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5};
        ctl = '{5'b0_1_10_0, 5'b0_1_11_0, 5'b1_1_10_0, 5'b1_1_11_0, 5'b0_1_00_0, 5'b0_1_01_0,
                5'b0_0_00_0, 5'b0_0_01_0, 5'b0_0_10_0, 5'b0_0_11_0, 5'b0_0_00_0, 5'b0_0_01_0};
        exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            rs1_data = r1[i]; rs2_data = r2[i];
            unsign = ctl[i][4]; brn_enable = ctl[i][3]; brn_signal = ctl[i][2:1];
            #1;
            total++;
            if (br_lt !== exp[i][1] || br_eq !== (r1[i] == r2[i])) begin
                bad++;
                $display("FAIL branch_cmp[%0d]: got lt=%b eq=%b want lt=%b", i, br_lt, br_eq, exp[i][1]);
            end
            @(posedge clock); #1;
            total++;
            if (br_tk !== exp[i][0] || redirect !== exp[i][0]) begin
                bad++;
                $display("FAIL branch_tk[%0d]: got tk=%b rd=%b want %b", i, br_tk, redirect, exp[i][0]);
            end
        end
    endtask

    task automatic test_jump_bubble();
        clear_inputs();
        pc_jump = 1'b1; rs1_data = 32'd1; rs2_data = 32'd2;
        @(posedge clock); #1;
        total++;
        if (redirect !== 1'b1 || br_tk !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL jump: got rd=%b tk=%b v=%b want 1/0/1", redirect, br_tk, out_valid);
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
        total++;
        if (redirect !== 1'b0 || out_valid !== 1'b0 || br_tk !== 1'b0) begin
            bad++; $display("FAIL bubble: got rd=%b v=%b tk=%b want 0/0/0", redirect, out_valid, br_tk);
        end
        // Illegal branch+jump combination: redirect wins, taken follows condition (BEQ false)
        in_valid = 1'b1; brn_enable = 1'b1; brn_signal = 2'b00;
        @(posedge clock); #1;
        total++;
        if (redirect !== 1'b1 || br_tk !== 1'b0) begin
            bad++; $display("FAIL brn_and_jump: got rd=%b tk=%b want 1/0", redirect, br_tk);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_alu;
        logic        e_tk, e_rd, e_v;
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            e_alu = model_alu(cur_a(), cur_b(), alu_sel);
            e_tk  = in_valid & model_tk(rs1_data, rs2_data, unsign, brn_enable, brn_signal);
            e_rd  = in_valid & (model_tk(rs1_data, rs2_data, unsign, brn_enable, brn_signal) | pc_jump);
            e_v   = in_valid;
            #1;
            total++;
            if (br_eq !== (rs1_data == rs2_data) || br_lt !== model_lt(rs1_data, rs2_data, unsign)) begin
                bad++;
                $display("FAIL rand_cmp[%0d]: got eq=%b lt=%b want eq=%b lt=%b", i, br_eq, br_lt,
                         rs1_data == rs2_data, model_lt(rs1_data, rs2_data, unsign));
            end
            @(posedge clock); #1;
            total++;
            if (alu_out !== e_alu || br_tk !== e_tk || redirect !== e_rd || out_valid !== e_v) begin
                bad++;
                $display("FAIL rand[%0d] op=%0d: got alu=%h tk=%b rd=%b v=%b want alu=%h tk=%b rd=%b v=%b",
                         i, alu_sel, alu_out, br_tk, redirect, out_valid, e_alu, e_tk, e_rd, e_v);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        pc_jump = 1'b1; rs1_data = 32'h1234; rs2_data = 32'h1;
        @(posedge clock); #1;
        total++;
        if (redirect !== 1'b1) begin
            bad++; $display("FAIL async_pre: got rd=%b want 1", redirect);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (redirect !== 1'b0 || out_valid !== 1'b0 || alu_out !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got rd=%b v=%b alu=%h want 0/0/0", redirect, out_valid, alu_out);
        end
        #1 reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (redirect !== 1'b1 || alu_out !== 32'h1235) begin
            bad++; $display("FAIL async_release: got rd=%b alu=%h want 1/00001235", redirect, alu_out);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu_sweep();
        test_operand_mux();
        test_branch();
        test_jump_bubble();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
